// File: rtl/dfp_line_arbiter.sv
// rtl/dfp_line_arbiter.sv - round-robin I/D cache line-port arbiter
// Registers the winning request onto mem_* and routes the completion pulse back to the owner.
module dfp_line_arbiter #(
  parameter int CNT_W   = 16,
  parameter bit FIRST_D = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      i_addr,
  input  logic             i_read,
  input  logic             i_write,
  input  logic [255:0]     i_wdata,
  output logic [255:0]     i_rdata,
  output logic             i_resp,
  input  logic [31:0]      d_addr,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [255:0]     d_wdata,
  output logic [255:0]     d_rdata,
  output logic             d_resp,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  output logic             mem_write,
  output logic [255:0]     mem_wdata,
  input  logic [255:0]     mem_rdata,
  input  logic             mem_resp,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt
);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

  state_t state, state_next;
  logic   rr_last;  // 1: D was served last, 0: I was served last
  logic   req_i, req_d, grant_i, grant_d;
  logic   sel_read, sel_write;
  logic [31:0]  sel_addr;
  logic [255:0] sel_wdata;

  assign req_i   = i_read | i_write;
  assign req_d   = d_read | d_write;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && (!req_d || rr_last)) begin
          grant_i    = 1'b1;
          state_next = OWN_I;
        end else if (req_d) begin
          grant_d    = 1'b1;
          state_next = OWN_D;
        end
      end
      OWN_I: if (mem_resp) begin
        i_resp     = 1'b1;
        state_next = IDLE;
      end
      OWN_D: if (mem_resp) begin
        d_resp     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_addr  = grant_d ? d_addr  : i_addr;
    sel_wdata = grant_d ? d_wdata : i_wdata;
    sel_read  = grant_d ? d_read  : i_read;
    sel_write = grant_d ? d_write : i_write;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      err         <= 1'b0;
      rr_last     <= ~FIRST_D;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else begin
      if (grant_i || grant_d) begin
        mem_addr  <= sel_addr & 32'hffff_ffe0;
        mem_wdata <= sel_wdata;
        // Simultaneous read+write is a protocol error; the write wins.
        mem_read  <= sel_read & ~sel_write;
        mem_write <= sel_write;
        if (sel_read && sel_write) err <= 1'b1;
      end
      if (grant_i && (i_grant_cnt != '1)) i_grant_cnt <= i_grant_cnt + 1'b1;
      if (grant_d && (d_grant_cnt != '1)) d_grant_cnt <= d_grant_cnt + 1'b1;
      if (i_resp || d_resp) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        rr_last   <= d_resp;
      end
      if ((state == IDLE) && mem_resp) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dfp_line_arbiter.sv
// tb/tb_dfp_line_arbiter.sv - directed self-checking bench for dfp_line_arbiter
module tb_dfp_line_arbiter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      i_addr, d_addr, mem_addr;
  logic             i_read, i_write, d_read, d_write;
  logic [255:0]     i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic             i_resp, d_resp, mem_read, mem_write, mem_resp, busy, err;
  logic [CNT_W-1:0] i_grant_cnt, d_grant_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] P  = {8{32'hcafe_0001}};
  localparam logic [255:0] W  = {8{32'h1234_5678}};
  localparam logic [255:0] W2 = {8{32'hdead_beef}};

  dfp_line_arbiter #(.CNT_W(CNT_W), .FIRST_D(1'b0)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .err(err), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_addr = '0; i_read = 0; i_write = 0; i_wdata = '0;
    d_addr = '0; d_read = 0; d_write = 0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Completes the current transaction; caller has already let the grant settle.
  task automatic complete(input string tag, input logic exp_i, input logic exp_d);
    mem_resp = 1'b1;
    mem_rdata = P;
    #1;
    check({tag, " i_resp"}, i_resp, exp_i);
    check({tag, " d_resp"}, d_resp, exp_d);
    tick();
    mem_resp = 1'b0;
  endtask

  initial begin
    do_reset();
    // Reset values observed before release
    rst = 1'b0;
    #1;
    check("rst mem_read", mem_read, 0);
    check("rst mem_write", mem_write, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst cnt", {i_grant_cnt, d_grant_cnt}, 0);
    tick();
    rst = 1'b1;

    // 1. Lone I read
    i_read = 1; i_addr = 32'h0000_1044;
    tick();
    check("t1 mem_read", mem_read, 1);
    check("t1 mem_addr", mem_addr, 32'h0000_1040);
    check("t1 busy", busy, 1);
    mem_resp = 1; mem_rdata = P;
    #1;
    check("t1 i_resp", i_resp, 1);
    check("t1 i_rdata", i_rdata, P);
    check("t1 d_resp", d_resp, 0);
    i_read = 0;
    tick();
    mem_resp = 0;
    check("t1 mem_read drop", mem_read, 0);
    check("t1 busy drop", busy, 0);
    check("t1 i_cnt", i_grant_cnt, 1);

    // 2. Simultaneous I read / D write, I wins first
    do_reset();
    i_read = 1; i_addr = 32'h0000_1000;
    d_write = 1; d_addr = 32'h8000_0020; d_wdata = W;
    tick();
    check("t2 first read", mem_read, 1);
    check("t2 first addr", mem_addr, 32'h0000_1000);
    i_read = 0;
    complete("t2 I", 1, 0);
    check("t2 bubble write", mem_write, 0);
    tick();
    check("t2 D write", mem_write, 1);
    check("t2 D wdata", mem_wdata, W);
    check("t2 D addr", mem_addr, 32'h8000_0020);
    d_write = 0;
    complete("t2 D", 0, 1);

    // 3. Both hold requests: strict alternation
    do_reset();
    i_read = 1; i_addr = 32'h0000_0100;
    d_read = 1; d_addr = 32'h0000_0200;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t3 addr %0d", k), mem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      complete($sformatf("t3 %0d", k), (k % 2 == 0), (k % 2 == 1));
    end
    i_read = 0; d_read = 0;
    check("t3 i_cnt", i_grant_cnt, 3);
    check("t3 d_cnt", d_grant_cnt, 3);
    check("t3 err", err, 0);
    tick();

    // 4. Owner inputs change mid-transaction
    do_reset();
    d_write = 1; d_addr = 32'h0000_4000; d_wdata = W;
    tick();
    d_addr = 32'h0000_5000; d_wdata = W2;
    tick();
    tick();
    check("t4 addr held", mem_addr, 32'h0000_4000);
    check("t4 wdata held", mem_wdata, W);
    d_write = 0;
    complete("t4", 0, 1);

    // 5. Protocol errors
    do_reset();
    mem_resp = 1;
    #1;
    check("t5 idle i_resp", i_resp, 0);
    check("t5 idle d_resp", d_resp, 0);
    tick();
    mem_resp = 0;
    check("t5 err idle resp", err, 1);
    do_reset();
    d_read = 1; d_write = 1; d_addr = 32'h0000_0040;
    tick();
    check("t5 rw write", mem_write, 1);
    check("t5 rw read", mem_read, 0);
    check("t5 rw err", err, 1);
    d_read = 0; d_write = 0;
    complete("t5 rw", 0, 1);

    // 6. Counter saturation, then reset mid-transaction
    do_reset();
    i_read = 1; i_addr = 32'h0000_0080;
    for (int k = 0; k < 5; k++) begin
      tick();
      complete($sformatf("t6 %0d", k), 1, 0);
    end
    check("t6 i_cnt sat", i_grant_cnt, 3);
    check("t6 d_cnt", d_grant_cnt, 0);
    tick();
    check("t6 own mem_read", mem_read, 1);
    #2;
    rst = 1'b0;
    mem_resp = 1;
    #1;
    check("t6 rst mem_read", mem_read, 0);
    check("t6 rst busy", busy, 0);
    check("t6 rst i_resp", i_resp, 0);
    check("t6 rst cnt", i_grant_cnt, 0);
    mem_resp = 0;
    i_read = 0;
    tick();
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
